// File: rtl/cmd_pkg.sv
// Shared types and constants for the command line responder.
// The help strings are only present when CMD_HELP_EN is defined.
package cmd_pkg;

    localparam int unsigned MAX_CMD_LEN  = 32;
    localparam int unsigned MAX_RESP_LEN = 63;

    typedef enum logic [2:0] {
        StIdle,
        StLatch,
        StDecode,
        StEmit,
        StGap,
        StDone,
        StWaitAck
    } state_e;

    typedef struct packed {
        logic echo;
        logic len;
        logic help;
        logic empty;
        logic unknown;
    } cmd_class_t;

    localparam logic [7:0] ASCII_SPACE = 8'h20;
    localparam logic [7:0] ASCII_ZERO  = 8'h30;

    // String literals hold the first character in the top byte; lines want it in byte 0.
    function automatic logic [511:0] str_to_line(input logic [511:0] s, input int unsigned n);
        logic [511:0] line;
        line = '0;
        for (int unsigned i = 0; i < n; i++) begin
            line[8*i +: 8] = s[8*(n-1-i) +: 8];
        end
        return line;
    endfunction

    localparam logic [511:0] KW_ECHO      = str_to_line(512'("echo"), 4);
    localparam logic [511:0] KW_LEN       = str_to_line(512'("len"), 3);
    localparam logic [511:0] UNKNOWN_LINE = str_to_line(512'("unknown command"), 15);
    localparam logic [6:0]   UNKNOWN_LEN  = 7'd15;

`ifdef CMD_HELP_EN
    localparam logic [511:0] KW_HELP    = str_to_line(512'("help"), 4);
    localparam logic [511:0] HELP_LINE0 = str_to_line(512'("echo <text>"), 11);
    localparam logic [6:0]   HELP_LEN0  = 7'd11;
    localparam logic [511:0] HELP_LINE1 = str_to_line(512'("len <text>"), 10);
    localparam logic [6:0]   HELP_LEN1  = 7'd10;
`endif

endpackage

// File: rtl/cmd_keyword_match.sv
// Classifies a latched command line into a one-hot command class plus argument offset.
// The "help" keyword is only recognised when CMD_HELP_EN is defined.
module cmd_keyword_match
    import cmd_pkg::*;
(
    input  logic [5:0]  cmd_len,
    input  logic [39:0] cmd_head,   // first five characters of the latched line
    output cmd_class_t  cmd_class,
    output logic [5:0]  arg_offset
);

    logic is_echo;
    logic is_len;
    logic is_help;

    always_comb begin
        is_echo = (cmd_len >= 6'd4) && (cmd_head[31:0] == KW_ECHO[31:0]) &&
                  ((cmd_len == 6'd4) || (cmd_head[39:32] == ASCII_SPACE));
        is_len  = (cmd_len >= 6'd3) && (cmd_head[23:0] == KW_LEN[23:0]) &&
                  ((cmd_len == 6'd3) || (cmd_head[31:24] == ASCII_SPACE));
`ifdef CMD_HELP_EN
        is_help = (cmd_len == 6'd4) && (cmd_head[31:0] == KW_HELP[31:0]);
`else
        is_help = 1'b0;
`endif

        cmd_class  = '0;
        arg_offset = 6'd0;
        if (cmd_len == 6'd0) begin
            cmd_class.empty = 1'b1;
        end else if (is_echo) begin
            cmd_class.echo = 1'b1;
            arg_offset     = 6'd5;
        end else if (is_len) begin
            cmd_class.len = 1'b1;
            arg_offset    = 6'd4;
        end else if (is_help) begin
            cmd_class.help = 1'b1;
        end else begin
            cmd_class.unknown = 1'b1;
        end
    end

endmodule

// File: rtl/cmd_line_responder.sv
// Command-side terminal endpoint: latches a command line, decodes it and streams response lines.
// Optional feature macro: CMD_HELP_EN enables the two-line "help" command.
module cmd_line_responder
    import cmd_pkg::*;
(
    input  logic         clk,
    input  logic         rst,
    input  logic         cmd_ready,
    input  logic [5:0]   cmd_len,
    input  logic [255:0] cmd_line,
    output logic         cmd_next,
    output logic         resp_ready,
    output logic [6:0]   resp_len,
    output logic [511:0] resp_line,
    input  logic         resp_next,
    output logic         solved,
    input  logic         solved_ack
);

    state_e       state_q, state_d;
    logic [5:0]   cmd_len_q, cmd_len_d;
    logic [255:0] cmd_line_q, cmd_line_d;
    logic [1:0]   line_cnt_q, line_cnt_d;
    logic [1:0]   line_idx_q, line_idx_d;
    logic [6:0]   resp_len_q, resp_len_d;
    logic [511:0] resp_line_q, resp_line_d;

    logic [5:0]   len_clamped;
    logic [255:0] masked_line;
    cmd_class_t   cmd_class;
    logic [5:0]   arg_offset;
    logic [5:0]   arg_len, tens, ones;
    logic [1:0]   line0_cnt;
    logic [6:0]   line0_len;
    logic [511:0] line0_line;

    // Bytes past the command length are zeroed so echo payloads pad with 0.
    always_comb begin
        len_clamped = (cmd_len > 6'(MAX_CMD_LEN)) ? 6'(MAX_CMD_LEN) : cmd_len;
        for (int unsigned i = 0; i < MAX_CMD_LEN; i++) begin
            masked_line[8*i +: 8] = (6'(i) < len_clamped) ? cmd_line[8*i +: 8] : 8'h00;
        end
    end

    cmd_keyword_match u_match (
        .cmd_len    (cmd_len_q),
        .cmd_head   (cmd_line_q[39:0]),
        .cmd_class  (cmd_class),
        .arg_offset (arg_offset)
    );

    // First response line, built from the decoded class.
    always_comb begin
        arg_len    = (cmd_len_q > arg_offset) ? (cmd_len_q - arg_offset) : 6'd0;
        tens       = arg_len / 6'd10;
        ones       = arg_len % 6'd10;
        line0_cnt  = 2'd1;
        line0_len  = '0;
        line0_line = '0;
        if (cmd_class.empty) begin
            line0_cnt = 2'd0;
        end else if (cmd_class.echo) begin
            line0_len  = {1'b0, arg_len};
            line0_line = {256'b0, cmd_line_q >> {arg_offset, 3'b000}};
        end else if (cmd_class.len) begin
            if (tens == 6'd0) begin
                line0_len        = 7'd1;
                line0_line[7:0]  = ASCII_ZERO + {2'b00, ones};
            end else begin
                line0_len        = 7'd2;
                line0_line[7:0]  = ASCII_ZERO + {2'b00, tens};
                line0_line[15:8] = ASCII_ZERO + {2'b00, ones};
            end
`ifdef CMD_HELP_EN
        end else if (cmd_class.help) begin
            line0_cnt  = 2'd2;
            line0_len  = HELP_LEN0;
            line0_line = HELP_LINE0;
        end else if (cmd_class.unknown) begin
`else
        end else if (cmd_class.help || cmd_class.unknown) begin
`endif
            line0_len  = UNKNOWN_LEN;
            line0_line = UNKNOWN_LINE;
        end
    end

    always_comb begin
        state_d     = state_q;
        cmd_len_d   = cmd_len_q;
        cmd_line_d  = cmd_line_q;
        line_cnt_d  = line_cnt_q;
        line_idx_d  = line_idx_q;
        resp_len_d  = resp_len_q;
        resp_line_d = resp_line_q;
        unique case (state_q)
            StIdle: begin
                if (cmd_ready) begin
                    cmd_len_d  = len_clamped;
                    cmd_line_d = masked_line;
                    state_d    = StLatch;
                end
            end
            StLatch: state_d = StDecode;
            StDecode: begin
                line_cnt_d  = line0_cnt;
                line_idx_d  = 2'd0;
                resp_len_d  = line0_len;
                resp_line_d = line0_line;
                state_d     = (line0_cnt != 2'd0) ? StEmit : StDone;
            end
            StEmit: begin
                if (resp_next) begin
                    line_idx_d = line_idx_q + 2'd1;
                    state_d    = StGap;
                end
            end
            StGap: begin
                if (line_idx_q < line_cnt_q) begin
`ifdef CMD_HELP_EN
                    resp_len_d  = HELP_LEN1;
                    resp_line_d = HELP_LINE1;
`endif
                    state_d = StEmit;
                end else begin
                    state_d = StDone;
                end
            end
            StDone:    state_d = solved_ack ? StIdle : StWaitAck;
            StWaitAck: if (solved_ack) state_d = StIdle;
            default:   state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= StIdle;
            cmd_len_q   <= '0;
            cmd_line_q  <= '0;
            line_cnt_q  <= '0;
            line_idx_q  <= '0;
            resp_len_q  <= '0;
            resp_line_q <= '0;
        end else begin
            state_q     <= state_d;
            cmd_len_q   <= cmd_len_d;
            cmd_line_q  <= cmd_line_d;
            line_cnt_q  <= line_cnt_d;
            line_idx_q  <= line_idx_d;
            resp_len_q  <= resp_len_d;
            resp_line_q <= resp_line_d;
        end
    end

    always_comb begin
        cmd_next   = (state_q == StLatch);
        resp_ready = (state_q == StEmit);
        resp_len   = resp_ready ? resp_len_q : '0;
        resp_line  = resp_ready ? resp_line_q : '0;
        solved     = (state_q == StDone);
    end

endmodule

// File: tb/tb_cmd_line_responder.sv
// Self-checking bench for cmd_line_responder: directed and random commands against a string model.
`timescale 1ns/1ps
module tb_cmd_line_responder;

    logic         clk = 1'b0;
    logic         rst;
    logic         cmd_ready;
    logic [5:0]   cmd_len;
    logic [255:0] cmd_line;
    logic         cmd_next;
    logic         resp_ready;
    logic [6:0]   resp_len;
    logic [511:0] resp_line;
    logic         resp_next;
    logic         solved;
    logic         solved_ack;

    int    checks   = 0;
    int    failures = 0;
    string exp_lines[$];

    always #5 clk = ~clk;

    cmd_line_responder u_dut (
        .clk        (clk),
        .rst        (rst),
        .cmd_ready  (cmd_ready),
        .cmd_len    (cmd_len),
        .cmd_line   (cmd_line),
        .cmd_next   (cmd_next),
        .resp_ready (resp_ready),
        .resp_len   (resp_len),
        .resp_line  (resp_line),
        .resp_next  (resp_next),
        .solved     (solved),
        .solved_ack (solved_ack)
    );

    // Reference: the list of response strings a command should produce.
    function automatic void model(input string c);
        int n;
        n = c.len();
        exp_lines.delete();
        if (n == 0) return;
        if (n >= 4 && c.substr(0, 3) == "echo" && (n == 4 || c[4] == 8'h20)) begin
            exp_lines.push_back(n > 5 ? c.substr(5, n - 1) : "");
        end else if (n >= 3 && c.substr(0, 2) == "len" && (n == 3 || c[3] == 8'h20)) begin
            exp_lines.push_back($sformatf("%0d", n > 4 ? n - 4 : 0));
`ifdef CMD_HELP_EN
        end else if (c == "help") begin
            exp_lines.push_back("echo <text>");
            exp_lines.push_back("len <text>");
`endif
        end else begin
            exp_lines.push_back("unknown command");
        end
    endfunction

    function automatic logic [511:0] to_line(input string s);
        logic [511:0] v;
        v = '0;
        for (int i = 0; i < s.len(); i++) v[8*i +: 8] = s[i];
        return v;
    endfunction

    function automatic string rand_text(input int n);
        string s;
        byte   ch;
        s = "";
        for (int i = 0; i < n; i++) begin
            ch = ($urandom_range(0, 5) == 0) ? 8'h20 : 8'($urandom_range(33, 126));
            s  = $sformatf("%s%c", s, ch);
        end
        return s;
    endfunction

    // Garbage past the command length must not influence anything.
    task automatic drive_cmd(input string c);
        logic [255:0] v;
        for (int i = 0; i < 8; i++) v[32*i +: 32] = $urandom;
        for (int i = 0; i < c.len(); i++) v[8*i +: 8] = c[i];
        cmd_line = v;
        cmd_len  = 6'(c.len());
    endtask

    task automatic run_cmd(input string c);
        int cyc, line_no, wait_cnt, lows, ack_wait, solved_seen, extra_next;
        int last_next_cyc, exp_cyc;
        bit prev_rdy, finished;
        model(c);
        @(negedge clk);
        solved_ack = 1'b0;
        resp_next  = 1'b0;
        drive_cmd(c);
        cmd_ready = 1'b1;
        @(negedge clk);
        checks++;
        if (cmd_next !== 1'b1) begin
            failures++;
            $display("FAIL cmd_next [%s]: got=%b exp=1", c, cmd_next);
        end
        cmd_ready = 1'($urandom_range(0, 1));
        cyc = 1; line_no = 0; wait_cnt = 0; lows = 0; ack_wait = -1;
        solved_seen = 0; extra_next = 0; last_next_cyc = 1;
        prev_rdy = 1'b0; finished = 1'b0;
        while (!finished && cyc < 200) begin
            @(negedge clk);
            cyc++;
            resp_next  = 1'b0;
            solved_ack = 1'b0;
            if (cmd_next) extra_next++;
            if (resp_ready) begin
                if (!prev_rdy) begin
                    checks++;
                    if (line_no == 0 && cyc != 3) begin
                        failures++;
                        $display("FAIL resp_latency [%s]: got cycle %0d exp 3", c, cyc);
                    end else if (line_no > 0 && lows != 1) begin
                        failures++;
                        $display("FAIL gap [%s]: got %0d low cycles exp 1", c, lows);
                    end
                    wait_cnt = $urandom_range(0, 2);
                end
                checks++;
                if (line_no >= exp_lines.size()) begin
                    failures++;
                    $display("FAIL extra_line [%s]: got line %0d exp %0d lines",
                             c, line_no + 1, exp_lines.size());
                end else if (resp_len !== 7'(exp_lines[line_no].len()) ||
                             resp_line !== to_line(exp_lines[line_no])) begin
                    failures++;
                    $display("FAIL line%0d [%s]: got len=%0d data=%h exp len=%0d data=%h",
                             line_no, c, resp_len, resp_line, exp_lines[line_no].len(),
                             to_line(exp_lines[line_no]));
                end
                if (wait_cnt == 0) begin
                    resp_next     = 1'b1;
                    line_no++;
                    last_next_cyc = cyc;
                    lows          = 0;
                end else begin
                    wait_cnt--;
                end
            end else begin
                lows++;
                resp_next = ($urandom_range(0, 3) == 0);
            end
            prev_rdy = resp_ready;
            if (solved) begin
                solved_seen++;
                if (solved_seen == 1) begin
                    exp_cyc = (exp_lines.size() == 0) ? 3 : last_next_cyc + 2;
                    checks++;
                    if (cyc != exp_cyc || line_no != exp_lines.size()) begin
                        failures++;
                        $display("FAIL solved_timing [%s]: got cycle %0d lines %0d exp cycle %0d lines %0d",
                                 c, cyc, line_no, exp_cyc, exp_lines.size());
                    end
                    ack_wait = $urandom_range(0, 2);
                end
            end
            if (ack_wait == 0) begin
                solved_ack = 1'b1;
                cmd_ready  = 1'b0;
                finished   = 1'b1;
            end else if (ack_wait > 0) begin
                ack_wait--;
            end
        end
        checks++;
        if (!finished) begin
            failures++;
            $display("FAIL timeout [%s]: got no completion in %0d cycles exp solved", c, cyc);
        end
        checks++;
        if (extra_next != 0 || solved_seen != 1 || line_no != exp_lines.size()) begin
            failures++;
            $display("FAIL protocol [%s]: got extra_next=%0d solved=%0d lines=%0d exp 0/1/%0d",
                     c, extra_next, solved_seen, line_no, exp_lines.size());
        end
    endtask

    task automatic test_reset();
        rst = 1'b1; cmd_ready = 1'b0; cmd_len = '0; cmd_line = '0;
        resp_next = 1'b0; solved_ack = 1'b0;
        repeat (3) @(negedge clk);
        checks++;
        if ({cmd_next, resp_ready, resp_len, resp_line, solved} !== '0) begin
            failures++;
            $display("FAIL reset_outputs: got next=%b rdy=%b len=%0d solved=%b exp all 0",
                     cmd_next, resp_ready, resp_len, solved);
        end
        rst = 1'b0;
        repeat (2) @(negedge clk);
        checks++;
        if ({cmd_next, resp_ready, solved} !== 3'b000) begin
            failures++;
            $display("FAIL idle_quiet: got next=%b rdy=%b solved=%b exp 000",
                     cmd_next, resp_ready, solved);
        end
    endtask

    task automatic test_echo();
        run_cmd("echo hi");
        run_cmd("echo");
        run_cmd("echo ");
        run_cmd("echo a b c");
    endtask

    task automatic test_len();
        run_cmd("len abcdefghijkl");
        run_cmd("len");
        run_cmd("len ");
        run_cmd("len 123456789");
        run_cmd("len abcdefghijklmnopqrstuvwxyz12");
    endtask

    task automatic test_empty();
        run_cmd("");
    endtask

    task automatic test_unknown();
        run_cmd("foo");
        run_cmd("echoX");
        run_cmd("lenient");
        run_cmd("ECHO hi");
        run_cmd("ech");
    endtask

    task automatic test_help();
        run_cmd("help");
        run_cmd("help me");
    endtask

    task automatic test_back_to_back();
        run_cmd("echo one");
        run_cmd("len xy");
        run_cmd("");
        run_cmd("echo two");
    endtask

    task automatic test_random();
        string c;
        for (int k = 0; k < 60; k++) begin
            case ($urandom_range(0, 7))
                0: c = {"echo ", rand_text($urandom_range(0, 27))};
                1: c = {"len ", rand_text($urandom_range(0, 28))};
                2: c = "len";
                3: c = "echo";
                4: c = rand_text($urandom_range(0, 32));
                5: c = "";
                6: c = {"echo", rand_text($urandom_range(1, 28))};
                default: c = ($urandom_range(0, 1) == 0) ? "help"
                                                         : {"len", rand_text($urandom_range(1, 29))};
            endcase
            run_cmd(c);
        end
    endtask

    task automatic test_reset_mid_emit();
        int n;
        int bad_solved;
        @(negedge clk);
        solved_ack = 1'b0;
        resp_next  = 1'b0;
        drive_cmd("echo hello");
        cmd_ready = 1'b1;
        @(negedge clk);
        cmd_ready = 1'b0;
        n = 0;
        while (!resp_ready && n < 10) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if (resp_ready !== 1'b1) begin
            failures++;
            $display("FAIL reach_emit: got resp_ready=%b exp 1", resp_ready);
        end
        rst = 1'b1;
        @(negedge clk);
        checks++;
        if ({cmd_next, resp_ready, resp_len, resp_line, solved} !== '0) begin
            failures++;
            $display("FAIL abort_outputs: got next=%b rdy=%b len=%0d solved=%b exp all 0",
                     cmd_next, resp_ready, resp_len, solved);
        end
        rst = 1'b0;
        bad_solved = 0;
        repeat (5) begin
            @(negedge clk);
            if (solved || resp_ready) bad_solved++;
        end
        checks++;
        if (bad_solved != 0) begin
            failures++;
            $display("FAIL abort_quiet: got %0d active cycles exp 0", bad_solved);
        end
        run_cmd("echo a");
    endtask

    initial begin
        test_reset();
        test_echo();
        test_len();
        test_empty();
        test_unknown();
        test_help();
        test_back_to_back();
        test_random();
        test_reset_mid_emit();
        @(negedge clk);
        solved_ack = 1'b0;
        resp_next  = 1'b0;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/cmd_line_responder.md
# cmd_line_responder

Command-side endpoint of the terminal line interface. It accepts one typed command line (up to 32 ASCII characters) from the video/terminal memory block, decodes a small fixed command set, and streams zero or more response lines (up to 63 characters each) back for display. It then signals completion so the terminal prints a new prompt and re-enables the keyboard. It sits between the terminal display block and any future command back-ends.

## Interface
Parameters:
- MAX_CMD_LEN, 32: maximum command characters accepted; must match the terminal's output line width.
- MAX_RESP_LEN, 63: maximum characters per response line.

Ports:
- clk  in  1  system clock; single clock domain.
- rst  in  1  reset; synchronous, active-high.
- cmd_ready  in  1  terminal holds a complete command line valid.
- cmd_len  in  6  command length in characters, 0..32.
- cmd_line  in  256  command text; character i is in bits [8i+7:8i].
- cmd_next  out  1  one-cycle pulse: the command is latched and the terminal may drop cmd_ready.
- resp_ready  out  1  a response line is valid; held until resp_next.
- resp_len  out  7  response length, 0..63.
- resp_line  out  512  response text; character i is in bits [8i+7:8i]; unused bytes are 0.
- resp_next  in  1  one-cycle pulse: the terminal has consumed the current line.
- solved  out  1  one-cycle pulse: the command has finished.
- solved_ack  in  1  one-cycle pulse: the terminal has processed solved.

## Operation
- States: IDLE, LATCH, DECODE, EMIT, GAP, DONE, WAIT_ACK.
- IDLE: when cmd_ready=1, copy cmd_len and cmd_line into internal registers and move to LATCH.
- LATCH: pulse cmd_next for one cycle, then move to DECODE.
- DECODE: compare the latched text in one cycle and set the line count, 0..2.
  - "echo" followed by end of line or a space: 1 line, the text after "echo ", which can be empty (length 0).
  - "len" followed by end of line or a space: 1 line, the decimal length of the text after "len ". Output has no leading zero, one or two digits, e.g. "0", "7", "28".
  - cmd_len=0: 0 lines.
  - Anything else: 1 line, "unknown command" (15 characters).
  - Keyword matching is case-sensitive. Characters beyond cmd_len are ignored.
- Next state after DECODE: EMIT if the line count is greater than 0, otherwise DONE.
- EMIT: drive resp_len and resp_line, and hold resp_ready=1 until resp_next=1. On resp_next, drop resp_ready and go to GAP.
- GAP: one cycle with resp_ready=0. Then go to EMIT for the next line, or to DONE after the last line.
- DONE: pulse solved for one cycle, then go to WAIT_ACK.
- WAIT_ACK: wait for solved_ack, then return to IDLE. cmd_ready is ignored in every state except IDLE.
- Arithmetic for "len":
  - Argument length = cmd_len − 4. With cmd_len=3 ("len" alone) the result is "0".
  - Decimal conversion is tens = arg/10, ones = arg%10, taken from a 6-bit value; arg is at most 28.
- Width rules:
  - Echo payload length = cmd_len − 5, clamped at 0.
  - resp_len is zero-extended to 7 bits.

## Timing
- Reset values: cmd_next=0, resp_ready=0, resp_len=0, resp_line=0, solved=0; state=IDLE; internal registers cleared.
- Reset mid-operation aborts within one cycle. No solved pulse is issued for the aborted command.
- cmd_ready high at edge N gives cmd_next=1 in cycle N+1 and resp_ready=1 in cycle N+3 at the earliest.
- resp_line and resp_len are stable for the whole time resp_ready=1.
- resp_next while resp_ready=0 is ignored.
- resp_next arriving in the same cycle resp_ready first rises is accepted.
- After the final resp_next, solved pulses 2 cycles later.
- solved_ack arriving in the same cycle as solved is accepted, and the block returns to IDLE the next cycle.
- Minimum command-to-command turnaround: the next cmd_ready is sampled in IDLE, one cycle after the ack.

## Configuration
- CMD_HELP_EN defined: "help" (exact, cmd_len=4) emits 2 lines, "echo <text>" (11 characters) and then "len <text>" (10 characters), with a GAP cycle between them.
- CMD_HELP_EN undefined: "help" takes the unknown-command path. The help string constants and the 2-line path are not synthesized.

## Structure
- Shared package cmd_pkg holds:
  - the state enum;
  - MAX_CMD_LEN and MAX_RESP_LEN;
  - byte constants for the keyword strings, "unknown command", and the help strings.
- Sub-module cmd_keyword_match: combinational. It takes the latched line and length, and returns a one-hot command class (echo, len, help, empty, unknown) plus the argument offset.
- The top level holds the state machine and the response line builder.

## Test plan
- "echo hi" (cmd_len=7) → cmd_next pulse; one line resp_len=2, bytes 0x68 0x69; then solved pulse; after ack, back in IDLE.
- "len abcdefghijkl" (cmd_len=16) → one line resp_len=2, "12" (0x31 0x32). "len" alone → "0".
- cmd_len=0 → cmd_next pulse, no resp_ready, solved pulse 2 cycles later.
- "foo" → one line resp_len=15, "unknown command". "echoX" also → "unknown command".
- Multi-line, CMD_HELP_EN defined: "help" → two lines, resp_ready low for exactly one cycle between them, then solved.
- Multi-line, CMD_HELP_EN undefined: "help" → "unknown command".
- Reset asserted during EMIT → next cycle all outputs are 0; a new "echo a" then completes normally with one line and one solved pulse.
